// File: rtl/exec_unit_mc_if.sv
// Handshake and operand/result bundle between the issue stage, exec_unit_mc and the memory stage.
interface exec_unit_mc_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en_z;
    logic             en_n;
    logic             en_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output flush, in_valid, opcode, a, b, en_z, en_n, en_v, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_v
    );

    modport slave (
        input  flush, in_valid, opcode, a, b, en_z, en_n, en_v, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/exec_unit_mc.sv
// Execute stage: saturating add/sub, logic ops, barrel shifts, iterative shift-add multiply,
// valid/ready on both sides and a registered Z/N/V flag file updated with the result.
module exec_unit_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    exec_unit_mc_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic             en_z_q, en_z_d;
    logic             en_n_q, en_n_d;
    logic             en_v_q, en_v_d;

    logic             in_ready_s;
    logic             accept_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             add_ov_s;
    logic             sub_ov_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_v_s;
    logic [WIDTH-1:0] mul_sum_s;

    // Handshake: the only combinational input-to-output path is out_ready -> in_ready.
    always_comb begin
        in_ready_s = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s && !bus.flush;
    end

    // Single-cycle datapath; overflow saturates toward the sign of operand a.
    always_comb begin
        shamt_s   = bus.b[SHW-1:0];
        sum_s     = bus.a + bus.b;
        diff_s    = bus.a - bus.b;
        add_ov_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ov_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
        alu_res_s = bus.b;
        alu_v_s   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_v_s = add_ov_s;
                if (add_ov_s) begin
                    alu_res_s = bus.a[WIDTH-1] ? SAT_NEG : SAT_POS;
                end else begin
                    alu_res_s = sum_s;
                end
            end
            OP_SUB: begin
                alu_v_s = sub_ov_s;
                if (sub_ov_s) begin
                    alu_res_s = bus.a[WIDTH-1] ? SAT_NEG : SAT_POS;
                end else begin
                    alu_res_s = diff_s;
                end
            end
            OP_XOR:  alu_res_s = bus.a ^ bus.b;
            OP_AND:  alu_res_s = bus.a & bus.b;
            OP_SLL:  alu_res_s = bus.a << shamt_s;
            OP_SRA:  alu_res_s = $signed(bus.a) >>> shamt_s;
            OP_ROR:  alu_res_s = WIDTH'({bus.a, bus.a} >> shamt_s);
            OP_MUL:  alu_res_s = ZERO_W;
            default: alu_res_s = bus.b;
        endcase
    end

    // One shift-add step per cycle: multiplicand moves left, multiplier bits consumed from the LSB.
    always_comb begin
        mul_sum_s = acc_q + (mplier_q[0] ? mcand_q : ZERO_W);
    end

    // FSM next state, multiplier iteration, result and flag register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        en_z_d   = en_z_q;
        en_n_d   = en_n_q;
        en_v_d   = en_v_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else if (accept_s) begin
            en_z_d = bus.en_z;
            en_n_d = bus.en_n;
            en_v_d = bus.en_v;
            if (bus.opcode == OP_MUL) begin
                state_d  = S_BUSY;
                cnt_d    = CNT_ZERO;
                acc_d    = ZERO_W;
                mcand_d  = bus.a;
                mplier_d = bus.b;
            end else begin
                state_d  = S_HOLD;
                result_d = alu_res_s;
                // Opcodes 8-15 pass b through and never touch the flag file.
                if (!bus.opcode[3]) begin
                    if (bus.en_z) begin
                        flag_z_d = (alu_res_s == ZERO_W);
                    end else begin
                        flag_z_d = flag_z_q;
                    end
                    if (bus.en_n) begin
                        flag_n_d = alu_res_s[WIDTH-1];
                    end else begin
                        flag_n_d = flag_n_q;
                    end
                    if (bus.en_v) begin
                        flag_v_d = alu_v_s;
                    end else begin
                        flag_v_d = flag_v_q;
                    end
                end else begin
                    flag_z_d = flag_z_q;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_HOLD;
                        result_d = mul_sum_s;
                        if (en_z_q) begin
                            flag_z_d = (mul_sum_s == ZERO_W);
                        end else begin
                            flag_z_d = flag_z_q;
                        end
                        if (en_n_q) begin
                            flag_n_d = mul_sum_s[WIDTH-1];
                        end else begin
                            flag_n_d = flag_n_q;
                        end
                        if (en_v_q) begin
                            flag_v_d = 1'b0;
                        end else begin
                            flag_v_d = flag_v_q;
                        end
                    end else begin
                        cnt_d    = cnt_q + CNT_ONE;
                        acc_d    = mul_sum_s;
                        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, datapath and architectural flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            acc_q    <= ZERO_W;
            mcand_q  <= ZERO_W;
            mplier_q <= ZERO_W;
            result_q <= ZERO_W;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
            en_z_q   <= 1'b0;
            en_n_q   <= 1'b0;
            en_v_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
            en_z_q   <= en_z_d;
            en_n_q   <= en_n_d;
            en_v_q   <= en_v_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.result    = result_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_v    = flag_v_q;

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Parametrised execute stage for the pipelined CPU. It extends the single-cycle ALU-plus-flag-register execute block with several additions: configurable datapath width, a valid/ready handshake on both sides, an iterative multi-cycle multiplier, saturating add/sub, and a synchronous flush for branch squash. Results and Z/N/V flags are registered and presented together to the memory stage.

## Interface
- WIDTH, 16, datapath width; power of two, at least 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of the in-flight operation and any held result
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  stage can accept this cycle
- opcode  in  4  operation select
- a, b  in  WIDTH  operands (two's complement)
- en_z, en_n, en_v  in  1  per-flag write enables, captured at accept
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  registered result
- flag_z, flag_n, flag_v  out  1  architectural flag register

## Operation
- Accept occurs when in_valid && in_ready. A captures opcode, a, b and the enables.
- Opcodes:
  - 0 ADD: saturating. On positive overflow the result is 0x7F..F; on negative overflow it is 0x80..0.
  - 1 SUB: a−b, saturating with the same rule as ADD.
  - 2 XOR, 3 AND.
  - 4 SLL, 5 SRA, 6 ROR: shift/rotate a by b[SHW-1:0], barrel, single-cycle.
  - 7 MUL: low WIDTH bits of a*b, computed by iterative shift-add at one bit per cycle over WIDTH cycles.
  - 8–15: result = b, and no flag is written regardless of enables.
- Flag values are computed on the final result:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow before saturation for ADD/SUB, and 0 for all other ops.
- Each flag is written only if its captured enable is 1. The write happens in the same cycle result is registered; otherwise the flag holds its value.
- FSM states:
  - IDLE: no result held.
  - BUSY: MUL iterating, with a counter from 0 to WIDTH-1.
  - HOLD: result held, out_valid=1.
- Transitions:
  - IDLE: accept of a non-MUL op goes to HOLD. Accept of MUL goes to BUSY.
  - BUSY: when the counter reaches WIDTH-1, register the result and flags and go to HOLD.
  - HOLD: out_ready with no new accept goes to IDLE. out_ready with an accept of a non-MUL op stays in HOLD with the new result. out_ready with an accept of MUL goes to BUSY.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). in_ready is 0 in BUSY and is 0 in HOLD while out_ready is 0.
- flush (synchronous) forces IDLE, drops any held result (out_valid=0) and aborts MUL.
  - Flags are not modified by a flushed operation.
  - An accept in the same cycle as flush is ignored.
  - flush has priority over completion in the same cycle.
- While HOLD and !out_ready, result and flags are stable.

## Timing
- Reset values:
  - state IDLE.
  - out_valid 0, result 0.
  - flag_z 0, flag_n 0, flag_v 0.
  - in_ready 1 on the first cycle after release.
- Single-cycle ops: accept at edge k gives out_valid=1 after edge k+1.
- MUL: accept at edge k gives out_valid=1 after edge k+WIDTH+1, i.e. 17 cycles for WIDTH=16.
- Throughput:
  - Non-MUL ops: one op per cycle when out_ready is held high.
  - MUL: one op per WIDTH+1 cycles.
- Reset asserted mid-BUSY or mid-HOLD immediately returns all outputs to reset values; the partial product is discarded.
- in_ready and flags are registered/FSM-derived. The only combinational input-to-output path is out_ready → in_ready.

## Test plan
- ADD, WIDTH=16:
  - a=0x7000, b=0x2000, all enables set → result 0x7FFF, Z=0, N=0, V=1, one cycle after accept.
  - a=0x8000, b=0x8000 → result 0x8000, N=1, V=1.
- SUB 0x0005−0x0005 with en_z=1, en_n=0, en_v=0, after a prior N=1 → result 0x0000, Z=1, N stays 1, V stays at its prior value.
- MUL 0x0003*0x0005 → in_ready=0 for 16 cycles, then result 0x000F with out_valid after 17 cycles. MUL 0x0100*0x0100 → 0x0000, Z=1.
- Backpressure: XOR 0x00FF^0x0F0F with out_ready=0 for 5 cycles → result 0x0FF0 held stable and in_ready=0. When out_ready rises together with in_valid, the next op is accepted in the same cycle.
- flush on cycle 8 of a MUL → out_valid stays 0, flags unchanged, in_ready=1 next cycle. A back-to-back ADD then completes normally.
- Reset asserted asynchronously mid-MUL and mid-HOLD → result 0, out_valid 0, all flags 0 immediately. Opcode 9 with b=0x1234 → result 0x1234, flags unchanged even with all enables set.
